mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide unit controller. Iterative shift-add
//                multiply and restoring divide (one bit per cycle) that
//                produce the HI/LO write, plus MTHI/MTLO pass-through and a
//                divide-by-zero flag.
//                Optional macro MDU_FAST_MULT_EN selects a single-cycle
//                32x32 multiplier for MULT/MULTU; divide stays iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    input  logic        flush,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wd,
    output logic [31:0] lo_wd,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [31:0] opnd;      // |multiplicand| or |divisor|
    logic [4:0]  cnt;
    logic        neg_q;     // negate product / quotient at the end
    logic        neg_r;     // negate remainder at the end
    logic        we_q;
    logic        dz_q;

    logic        sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`ifdef MDU_FAST_MULT_EN
    logic [63:0] fast_prod;
    logic [63:0] fast_fix;
`endif

    // Operand conditioning and one iteration step of multiply and divide.
    always_comb begin
        sgn       = ~op[0];
        abs_a     = (sgn && a[31]) ? (32'd0 - a) : a;
        abs_b     = (sgn && b[31]) ? (32'd0 - b) : b;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_trial = acc[63:31];
        div_ge    = (div_trial >= {1'b0, opnd});
        // When the trial fits, the true difference is below 2^32, so the
        // low 32 bits of the subtraction are exact.
        div_rem   = div_ge ? (div_trial[31:0] - opnd) : div_trial[31:0];
        div_next  = {div_rem, acc[30:0], div_ge};
        prod_fix  = neg_q ? (64'd0 - mul_next) : mul_next;
        quo_fix   = neg_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
        rem_fix   = neg_r ? (32'd0 - div_next[63:32]) : div_next[63:32];
`ifdef MDU_FAST_MULT_EN
        fast_prod = {32'd0, abs_a} * {32'd0, abs_b};
        fast_fix  = (sgn && (a[31] ^ b[31])) ? (64'd0 - fast_prod) : fast_prod;
`endif
    end

    // Control FSM with datapath registers and registered write outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 64'd0;
            opnd  <= 32'd0;
            cnt   <= 5'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            we_q  <= 1'b0;
            dz_q  <= 1'b0;
            hi_wd <= 32'd0;
            lo_wd <= 32'd0;
        end else begin
            we_q <= 1'b0;
            dz_q <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                3'b000, 3'b001: begin
`ifdef MDU_FAST_MULT_EN
                                    hi_wd <= fast_fix[63:32];
                                    lo_wd <= fast_fix[31:0];
                                    we_q  <= 1'b1;
                                    state <= DONE;
`else
                                    acc   <= {32'd0, abs_b};
                                    opnd  <= abs_a;
                                    cnt   <= 5'd0;
                                    neg_q <= sgn & (a[31] ^ b[31]);
                                    state <= MUL;
`endif
                                end
                                3'b010, 3'b011: begin
                                    if (b == 32'd0) begin
                                        dz_q  <= 1'b1;
                                        state <= DONE;
                                    end else begin
                                        acc   <= {32'd0, abs_a};
                                        opnd  <= abs_b;
                                        cnt   <= 5'd0;
                                        neg_q <= sgn & (a[31] ^ b[31]);
                                        neg_r <= sgn & a[31];
                                        state <= DIV;
                                    end
                                end
                                3'b100: begin
                                    hi_wd <= a;
                                    lo_wd <= lo_cur;
                                    we_q  <= 1'b1;
                                    state <= DONE;
                                end
                                3'b101: begin
                                    hi_wd <= hi_cur;
                                    lo_wd <= a;
                                    we_q  <= 1'b1;
                                    state <= DONE;
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        acc <= mul_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_wd <= prod_fix[63:32];
                            lo_wd <= prod_fix[31:0];
                            we_q  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DIV: begin
                        acc <= div_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_wd <= rem_fix;
                            lo_wd <= quo_fix;
                            we_q  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;   // DONE lasts one cycle
                endcase
            end
        end
    end

    // A flush landing on the write cycle suppresses the write in that cycle.
    always_comb begin
        busy     = (state != IDLE);
        hilo_we  = we_q & ~flush;
        div_zero = dz_q & ~flush;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Self-checking bench for mdu_ctrl: directed vectors plus
//                randomized operations against a 64-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b, hi_cur, lo_cur;
    logic        flush;
    logic        busy, hilo_we, div_zero;
    logic [31:0] hi_wd, lo_wd;

    int checks = 0;
    int errors = 0;

    mdu_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush), .busy(busy),
        .hilo_we(hilo_we), .hi_wd(hi_wd), .lo_wd(lo_wd), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of an operation, computed with wide arithmetic.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, y, hc, lc,
                                      output logic [31:0] rh, rl, output bit dz);
        longint          sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        dz = 1'b0; rh = 32'd0; rl = 32'd0;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        ux = longint'(x);          uy = longint'(y);
        case (o)
            3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
            3'd2: if (y == 0) dz = 1'b1;
                  else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            3'd3: if (y == 0) dz = 1'b1;
                  else begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
            3'd4: begin rh = x; rl = lc; end
            default: begin rl = x; rh = hc; end
        endcase
    endfunction

    // Issue one operation and observe it to completion.
    task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, b_i, hc, lc,
                          input bit noise, output logic [31:0] ghi, glo);
        logic [31:0] ehi, elo, whi, wlo;
        bit          edz;
        int          lat, we_cyc, we_n, dz_cyc, dz_n, busy_low;
        ref_model(op_i, a_i, b_i, hc, lc, ehi, elo, edz);
        if (edz || op_i[2]) lat = 1;
        else if (!op_i[1]) begin
`ifdef MDU_FAST_MULT_EN
            lat = 1;
`else
            lat = 33;
`endif
        end else lat = 33;
        we_cyc = -1; we_n = 0; dz_cyc = -1; dz_n = 0; busy_low = -1;
        whi = 32'd0; wlo = 32'd0;
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; hi_cur = hc; lo_cur = lc; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= lat + 3; cyc++) begin
            @(negedge clk);
            if (hilo_we) begin
                we_n++;
                if (we_cyc < 0) we_cyc = cyc;
                whi = hi_wd; wlo = lo_wd;
            end
            if (div_zero) begin dz_n++; if (dz_cyc < 0) dz_cyc = cyc; end
            if (!busy && busy_low < 0) busy_low = cyc;
            if (noise && cyc < lat) begin
                start = 1'b1; op = 3'($urandom_range(0, 5));
                a = $urandom; b = $urandom; hi_cur = $urandom; lo_cur = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (edz) begin
            check("dz_cycle", dz_cyc, 1);
            check("dz_count", dz_n, 1);
            check("dz_no_we", we_n, 0);
            check("dz_busy_low", busy_low, 2);
        end else begin
            check("we_cycle", we_cyc, lat);
            check("we_count", we_n, 1);
            check("no_dz", dz_n, 0);
            check("hi", whi, ehi);
            check("lo", wlo, elo);
            check("busy_low", busy_low, lat + 1);
        end
        ghi = whi; glo = wlo;
    endtask

    logic [31:0] h, l;
    int          cnt_we;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        hi_cur = 32'd0; lo_cur = 32'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(hilo_we), 0);
        check("rst_dz", 32'(div_zero), 0);
        check("rst_hi", hi_wd, 0);
        check("rst_lo", lo_wd, 0);
        @(negedge clk); rst = 1'b0;

        // Directed vectors with hand-computed results.
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 0, 0, 1'b0, h, l);
        check("mult_hi", h, 32'hFFFFFFFF); check("mult_lo", l, 32'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 0, 0, 1'b0, h, l);
        check("multu_hi", h, 32'h00000001); check("multu_lo", l, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 1'b1, h, l);
        check("div_hi", h, 32'hFFFFFFFF); check("div_lo", l, 32'hFFFFFFFD);
        run_op(3'd3, 32'd100, 32'd7, 0, 0, 1'b1, h, l);
        check("divu_hi", h, 32'd2); check("divu_lo", l, 32'd14);
        run_op(3'd3, 32'h80000000, 32'd0, 0, 0, 1'b0, h, l);
        run_op(3'd4, 32'h12345678, 32'd0, 32'h11111111, 32'hCAFEF00D, 1'b0, h, l);
        check("mthi_hi", h, 32'h12345678); check("mthi_lo", l, 32'hCAFEF00D);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, h, l);
        check("ovf_hi", h, 32'd0); check("ovf_lo", l, 32'h80000000);

        // Reserved opcodes produce no activity.
        for (int k = 6; k <= 7; k++) begin
            @(negedge clk); op = 3'(k); start = 1'b1;
            @(negedge clk); start = 1'b0;
            check("rsv_busy", 32'(busy), 0);
            check("rsv_we", 32'(hilo_we), 0);
        end

        // Flush at iteration 10 of a DIV.
        @(negedge clk); op = 3'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt_we = 0;
        repeat (9) begin @(negedge clk); cnt_we += int'(hilo_we); end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy", 32'(busy), 0);
        repeat (40) begin @(negedge clk); cnt_we += int'(hilo_we); end
        check("flush_no_we", cnt_we, 0);

        // Flush landing in the write cycle of an MTLO.
        @(negedge clk); op = 3'd5; a = 32'h55AA55AA; start = 1'b1;
        @(posedge clk); #1; flush = 1'b1; start = 1'b0;
        @(negedge clk);
        check("flush_done_we", 32'(hilo_we), 0);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("flush_done_busy", 32'(busy), 0);
        check("flush_done_we2", 32'(hilo_we), 0);

        // Asynchronous reset at iteration 20 of a MULT.
        @(negedge clk); op = 3'd0; a = 32'd77; b = 32'd99; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt_we = 0;
        repeat (19) begin @(negedge clk); cnt_we += int'(hilo_we); end
        rst = 1'b1; #1;
        check("rst_mid_busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;
        repeat (40) begin @(negedge clk); cnt_we += int'(hilo_we); end
        check("rst_no_we", cnt_we, 0);
        run_op(3'd1, 32'd3, 32'd5, 0, 0, 1'b0, h, l);
        check("after_rst_hi", h, 32'd0); check("after_rst_lo", l, 32'd15);

        // Randomized operations against the model.
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  ro;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 5));
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(ro, $urandom, rb, $urandom, $urandom, n[0], h, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
